// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: clears every general register after reset, then
// round-robin arbitrates writeback requesters onto RegWr/RW/BusW.
module regfile_write_arbiter #(
    parameter int NREQ           = 2,
    parameter int DATA_W         = 64,
    parameter int ADDR_W         = 5,
    parameter int ZERO_REG       = 31,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NREQ-1:0]          ReqValid,
    input  logic [NREQ*ADDR_W-1:0]   ReqAddr,
    input  logic [NREQ*DATA_W-1:0]   ReqData,
    output logic [NREQ-1:0]          ReqReady,
    output logic                     RegWr,
    output logic [ADDR_W-1:0]        RW,
    output logic [DATA_W-1:0]        BusW,
    output logic                     ClearDone
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] MAX_ADDR  = {ADDR_W{1'b1}};
    // The last clear index is the top register unless that one is the zero register.
    localparam logic [ADDR_W-1:0] LAST_IDX  = (ZERO_ADDR == MAX_ADDR) ? MAX_ADDR - 1'b1 : MAX_ADDR;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam state_t INIT_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    state_t               state;
    state_t               next_state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     ptr_next;
    logic [ADDR_W-1:0]    clr_cnt;
    logic [ADDR_W-1:0]    clear_addr;
    logic                 clear_last;
    logic                 run_active;
    logic [NREQ-1:0]      eligible;
    logic [NREQ-1:0]      zero_req;
    logic [NREQ-1:0]      grant_vec;
    logic                 grant_valid;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;

    assign clear_addr = (clr_cnt == ZERO_ADDR) ? clr_cnt + 1'b1 : clr_cnt;
    assign clear_last = (clear_addr == LAST_IDX);
    assign run_active = !Reset && (state == RUN);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= INIT_STATE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (clear_last) next_state = RUN;
            RUN:     next_state = RUN;
            default: next_state = INIT_STATE;
        endcase
    end

    // Zero-register requests are consumed in place; the rest compete from rr_ptr onward.
    always_comb begin
        int idx;
        idx         = 0;
        eligible    = '0;
        zero_req    = '0;
        grant_vec   = '0;
        grant_valid = 1'b0;
        sel_addr    = '0;
        sel_data    = '0;
        ptr_next    = rr_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (ReqValid[i]) begin
                if (ReqAddr[i*ADDR_W +: ADDR_W] == ZERO_ADDR) begin
                    zero_req[i] = 1'b1;
                end else begin
                    eligible[i] = 1'b1;
                end
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_valid && eligible[idx]) begin
                grant_valid    = 1'b1;
                grant_vec[idx] = 1'b1;
                sel_addr       = ReqAddr[idx*ADDR_W +: ADDR_W];
                sel_data       = ReqData[idx*DATA_W +: DATA_W];
                ptr_next       = (idx == NREQ - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    assign ReqReady = run_active ? (zero_req | grant_vec) : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            RegWr     <= 1'b0;
            RW        <= '0;
            BusW      <= '0;
            ClearDone <= 1'b0;
            rr_ptr    <= '0;
            clr_cnt   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    RegWr   <= 1'b1;
                    RW      <= clear_addr;
                    BusW    <= '0;
                    clr_cnt <= clear_addr + 1'b1;
                    if (clear_last) begin
                        ClearDone <= 1'b1;
                    end
                end
                RUN: begin
                    ClearDone <= 1'b1;
                    if (grant_valid) begin
                        RegWr  <= 1'b1;
                        RW     <= sel_addr;
                        BusW   <= sel_data;
                        rr_ptr <= ptr_next;
                    end else begin
                        RegWr  <= 1'b0;
                    end
                end
                default: begin
                    RegWr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: clear sequence, arbitration, zero-register
// absorption, reset during clear, and the no-clear configuration.
module tb_regfile_write_arbiter;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [9:0]    req_addr;
    logic [127:0]  req_data;
    logic [1:0]    req_ready;
    logic          reg_wr;
    logic [4:0]    rw;
    logic [63:0]   bus_w;
    logic          clear_done;

    logic          nc_reset;
    logic [1:0]    nc_valid;
    logic [9:0]    nc_addr;
    logic [127:0]  nc_data;
    logic [1:0]    nc_ready;
    logic          nc_reg_wr;
    logic [4:0]    nc_rw;
    logic [63:0]   nc_bus_w;
    logic          nc_clear_done;

    int total_checks = 0;
    int fail_checks  = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NREQ(2), .DATA_W(64), .ADDR_W(5), .ZERO_REG(31), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .Clk(clk), .Reset(reset), .ReqValid(req_valid), .ReqAddr(req_addr),
        .ReqData(req_data), .ReqReady(req_ready), .RegWr(reg_wr), .RW(rw),
        .BusW(bus_w), .ClearDone(clear_done)
    );

    regfile_write_arbiter #(
        .NREQ(2), .DATA_W(64), .ADDR_W(5), .ZERO_REG(31), .CLEAR_ON_RESET(1'b0)
    ) dut_nc (
        .Clk(clk), .Reset(nc_reset), .ReqValid(nc_valid), .ReqAddr(nc_addr),
        .ReqData(nc_data), .ReqReady(nc_ready), .RegWr(nc_reg_wr), .RW(nc_rw),
        .BusW(nc_bus_w), .ClearDone(nc_clear_done)
    );

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        total_checks++;
        assert (observed === expected)
        else begin
            fail_checks++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                                  input logic [63:0] d0, input logic [63:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  exp_ready [4];
        logic [4:0]  exp_rw    [4];
        logic [63:0] exp_data  [4];
        exp_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_rw    = '{5'd3, 5'd4, 5'd3, 5'd4};
        exp_data  = '{64'h33, 64'h44, 64'h33, 64'h44};

        reset    = 1'b1;
        nc_reset = 1'b1;
        nc_valid = 2'b00;
        nc_addr  = '0;
        nc_data  = '0;
        apply_stimulus(2'b00, 5'd0, 5'd0, 64'h0, 64'h0);

        tick();
        check_output("reset_regwr", 64'(reg_wr), 64'd0);
        check_output("reset_rw", 64'(rw), 64'd0);
        check_output("reset_busw", bus_w, 64'd0);
        check_output("reset_cleardone", 64'(clear_done), 64'd0);
        check_output("nc_reset_cleardone", 64'(nc_clear_done), 64'd0);
        apply_stimulus(2'b11, 5'd3, 5'd4, 64'h1, 64'h2);
        check_output("reset_ready_low", 64'(req_ready), 64'd0);

        // No-clear configuration: ready at once, no clear writes.
        nc_reset = 1'b0;
        tick();
        check_output("nc_cleardone", 64'(nc_clear_done), 64'd1);
        check_output("nc_no_clear_write", 64'(nc_reg_wr), 64'd0);
        nc_valid = 2'b01;
        nc_addr  = {5'd0, 5'd2};
        nc_data  = {64'h0, 64'h55};
        #1;
        check_output("nc_ready", 64'(nc_ready), 64'd1);
        tick();
        nc_valid = 2'b00;
        check_output("nc_regwr", 64'(nc_reg_wr), 64'd1);
        check_output("nc_rw", 64'(nc_rw), 64'd2);
        check_output("nc_busw", nc_bus_w, 64'h55);

        // Clear sequence with requesters pending throughout.
        reset = 1'b0;
        for (int i = 0; i < 31; i++) begin
            tick();
            check_output($sformatf("clear_regwr_%0d", i), 64'(reg_wr), 64'd1);
            check_output($sformatf("clear_rw_%0d", i), 64'(rw), 64'(i));
            check_output($sformatf("clear_busw_%0d", i), bus_w, 64'd0);
            if (i < 30) begin
                check_output($sformatf("clear_ready_%0d", i), 64'(req_ready), 64'd0);
                check_output($sformatf("clear_done_low_%0d", i), 64'(clear_done), 64'd0);
            end
            if (i == 29) begin
                apply_stimulus(2'b00, 5'd0, 5'd0, 64'h0, 64'h0);
            end
        end
        tick();
        check_output("clear_done_high", 64'(clear_done), 64'd1);
        check_output("run_idle_regwr", 64'(reg_wr), 64'd0);
        check_output("run_idle_rw_hold", 64'(rw), 64'd30);

        // Single requester.
        apply_stimulus(2'b01, 5'd5, 5'd0, 64'hDEAD, 64'h0);
        check_output("single_ready", 64'(req_ready), 64'd1);
        tick();
        apply_stimulus(2'b00, 5'd0, 5'd0, 64'h0, 64'h0);
        check_output("single_regwr", 64'(reg_wr), 64'd1);
        check_output("single_rw", 64'(rw), 64'd5);
        check_output("single_busw", bus_w, 64'hDEAD);
        tick();
        check_output("single_regwr_drop", 64'(reg_wr), 64'd0);
        check_output("single_rw_hold", 64'(rw), 64'd5);
        check_output("single_busw_hold", bus_w, 64'hDEAD);

        // Pointer sits at 1; grant requester 1 alone to bring it back to 0.
        apply_stimulus(2'b10, 5'd0, 5'd9, 64'h0, 64'h99);
        check_output("req1_ready", 64'(req_ready), 64'd2);
        tick();
        apply_stimulus(2'b00, 5'd0, 5'd0, 64'h0, 64'h0);
        check_output("req1_rw", 64'(rw), 64'd9);
        check_output("req1_busw", bus_w, 64'h99);

        // Both continuously valid: alternate grants.
        apply_stimulus(2'b11, 5'd3, 5'd4, 64'h33, 64'h44);
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(exp_ready[k]));
            tick();
            check_output($sformatf("rr_regwr_%0d", k), 64'(reg_wr), 64'd1);
            check_output($sformatf("rr_rw_%0d", k), 64'(rw), 64'(exp_rw[k]));
            check_output($sformatf("rr_busw_%0d", k), bus_w, exp_data[k]);
        end
        apply_stimulus(2'b00, 5'd0, 5'd0, 64'h0, 64'h0);

        // Zero-register request alongside a real one.
        apply_stimulus(2'b11, 5'd7, 5'd31, 64'h77, 64'hFF);
        check_output("zero_both_ready", 64'(req_ready), 64'd3);
        tick();
        apply_stimulus(2'b00, 5'd0, 5'd0, 64'h0, 64'h0);
        check_output("zero_regwr", 64'(reg_wr), 64'd1);
        check_output("zero_rw", 64'(rw), 64'd7);
        check_output("zero_busw", bus_w, 64'h77);

        apply_stimulus(2'b10, 5'd0, 5'd31, 64'h0, 64'hEE);
        check_output("zero_only_ready", 64'(req_ready), 64'd2);
        tick();
        apply_stimulus(2'b00, 5'd0, 5'd0, 64'h0, 64'h0);
        check_output("zero_only_no_write", 64'(reg_wr), 64'd0);
        check_output("zero_only_rw_hold", 64'(rw), 64'd7);

        // Pointer should still be 1.
        apply_stimulus(2'b11, 5'd8, 5'd10, 64'h88, 64'hAA);
        check_output("ptr_after_zero_ready", 64'(req_ready), 64'd2);
        tick();
        apply_stimulus(2'b00, 5'd0, 5'd0, 64'h0, 64'h0);
        check_output("ptr_after_zero_rw", 64'(rw), 64'd10);
        check_output("ptr_after_zero_busw", bus_w, 64'hAA);

        // Same destination from both: later grant wins.
        apply_stimulus(2'b11, 5'd6, 5'd6, 64'h61, 64'h62);
        check_output("same_addr_ready0", 64'(req_ready), 64'd1);
        tick();
        apply_stimulus(2'b10, 5'd0, 5'd6, 64'h0, 64'h62);
        check_output("same_addr_busw0", bus_w, 64'h61);
        check_output("same_addr_ready1", 64'(req_ready), 64'd2);
        tick();
        apply_stimulus(2'b00, 5'd0, 5'd0, 64'h0, 64'h0);
        check_output("same_addr_rw1", 64'(rw), 64'd6);
        check_output("same_addr_busw1", bus_w, 64'h62);

        // Reset in RUN, then reset in the middle of the clear.
        reset = 1'b1;
        apply_stimulus(2'b11, 5'd1, 5'd2, 64'h1, 64'h2);
        check_output("run_reset_ready", 64'(req_ready), 64'd0);
        tick();
        apply_stimulus(2'b00, 5'd0, 5'd0, 64'h0, 64'h0);
        check_output("run_reset_regwr", 64'(reg_wr), 64'd0);
        check_output("run_reset_cleardone", 64'(clear_done), 64'd0);
        reset = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            tick();
            check_output($sformatf("reclear_rw_%0d", i), 64'(rw), 64'(i));
        end
        reset = 1'b1;
        tick();
        check_output("midclear_regwr", 64'(reg_wr), 64'd0);
        check_output("midclear_cleardone", 64'(clear_done), 64'd0);
        check_output("midclear_rw", 64'(rw), 64'd0);
        reset = 1'b0;
        tick();
        check_output("restart_regwr", 64'(reg_wr), 64'd1);
        check_output("restart_rw0", 64'(rw), 64'd0);
        tick();
        check_output("restart_rw1", 64'(rw), 64'd1);

        $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
        $finish;
    end

endmodule
